// File: rtl/avg_filter_scheduler_if.sv
// Bundle of the request, filter-engine and result signals around
// avg_filter_scheduler.
//   slave  : view used by the scheduler itself
//   master : view used by whatever surrounds the scheduler (channels,
//            filter engine and downstream consumer)
// Signals:
//   req_valid/req_data/req_ready      per-channel sample handshake
//   filt_start/filt_ch/filt_in        request to the shared filter engine
//   filt_done/filt_result             engine response
//   out_valid/out_ch/out_data/out_ready  tagged result to downstream
//   busy, timeout_err                 status
interface avg_filter_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
);
    logic [NUM_CH-1:0]   req_valid;
    logic [8*NUM_CH-1:0] req_data;
    logic [NUM_CH-1:0]   req_ready;
    logic                filt_start;
    logic [CH_W-1:0]     filt_ch;
    logic [7:0]          filt_in;
    logic                filt_done;
    logic [7:0]          filt_result;
    logic                out_valid;
    logic [CH_W-1:0]     out_ch;
    logic [7:0]          out_data;
    logic                out_ready;
    logic                busy;
    logic                timeout_err;

    modport slave (
        input  req_valid, req_data, filt_done, filt_result, out_ready,
        output req_ready, filt_start, filt_ch, filt_in,
        output out_valid, out_ch, out_data, busy, timeout_err
    );

    modport master (
        output req_valid, req_data, filt_done, filt_result, out_ready,
        input  req_ready, filt_start, filt_ch, filt_in,
        input  out_valid, out_ch, out_data, busy, timeout_err
    );
endinterface

// File: rtl/avg_filter_scheduler.sv
// Shares one moving-average filter engine between NUM_CH sensor channels.
// Requests are granted round-robin, one transaction in flight at a time:
// accept a sample, pulse the engine, wait (bounded by TIMEOUT) for its done,
// then hold the tagged result until downstream takes it.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high; clears all state and outputs
//   bus    avg_filter_scheduler_if.slave (request, engine and result signals)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no transaction; grant the next requesting channel
// S_ISSUE | one-cycle start pulse to the engine, timer cleared
// S_WAIT  | waiting for filt_done; timer counts toward TIMEOUT-1
// S_OUT   | result presented; leaves on out_ready
module avg_filter_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    avg_filter_scheduler_if.slave bus
);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int SW    = CH_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant;
    logic              grant_vld;
    logic [SW-1:0]     scan_idx;
    logic [CH_W-1:0]   filt_ch_q;
    logic [7:0]        filt_in_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [7:0]        out_data_q;
    logic [TMR_W-1:0]  timer;
    logic              tmr_last;
    logic              timeout_err_q;
    logic [NUM_CH-1:0] req_ready_c;
    logic              accept, timer_clr, timer_inc;
    logic              take_done, take_timeout, out_fire;

    // Scan from the farthest offset down to offset 0 so the last hit wins,
    // which is the first requester at or after rr_ptr.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        scan_idx  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            scan_idx = {1'b0, rr_ptr} + SW'(i);
            if (scan_idx >= SW'(NUM_CH)) begin
                scan_idx = scan_idx - SW'(NUM_CH);
            end
            if (bus.req_valid[scan_idx[CH_W-1:0]]) begin
                grant     = scan_idx[CH_W-1:0];
                grant_vld = 1'b1;
            end
        end
    end

    assign tmr_last = (timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        req_ready_c  = '0;
        accept       = 1'b0;
        timer_clr    = 1'b0;
        timer_inc    = 1'b0;
        take_done    = 1'b0;
        take_timeout = 1'b0;
        out_fire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_vld) begin
                    accept             = 1'b1;
                    req_ready_c[grant] = 1'b1;
                    state_nxt          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_clr = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // a done landing on the last timer count still wins
                if (bus.filt_done) begin
                    take_done = 1'b1;
                    state_nxt = S_OUT;
                end else if (tmr_last) begin
                    take_timeout = 1'b1;
                    state_nxt    = S_OUT;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_fire  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr        <= '0;
            timer         <= '0;
            filt_ch_q     <= '0;
            filt_in_q     <= '0;
            out_ch_q      <= '0;
            out_data_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (accept) begin
                filt_ch_q <= grant;
                filt_in_q <= bus.req_data[8*grant +: 8];
            end
            if (timer_clr) begin
                timer <= '0;
            end else if (timer_inc) begin
                timer <= timer + 1'b1;
            end
            if (take_done) begin
                out_data_q <= bus.filt_result;
                out_ch_q   <= filt_ch_q;
            end
            if (take_timeout) begin
                out_data_q    <= 8'h00;
                out_ch_q      <= filt_ch_q;
                timeout_err_q <= 1'b1;
            end
            if (out_fire) begin
                rr_ptr <= (filt_ch_q == CH_W'(NUM_CH - 1)) ? '0 : filt_ch_q + 1'b1;
            end
        end
    end

    // req_ready is combinational; mask it during reset so every output is 0
    assign bus.req_ready   = reset ? '0 : req_ready_c;
    assign bus.filt_start  = (state == S_ISSUE);
    assign bus.filt_ch     = filt_ch_q;
    assign bus.filt_in     = filt_in_q;
    assign bus.out_valid   = (state == S_OUT);
    assign bus.out_ch      = out_ch_q;
    assign bus.out_data    = out_data_q;
    assign bus.busy        = (state != S_IDLE);
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_avg_filter_scheduler.sv
// Testbench for avg_filter_scheduler: directed vector table, hand-written
// corner sequences, and a randomized run against a transaction-level model.
module tb_avg_filter_scheduler;
    localparam int NUM_CH  = 4;
    localparam int CH_W    = 2;
    localparam int TIMEOUT = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    avg_filter_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

    avg_filter_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Filter engine stand-in: done pulses eng_delay cycles after filt_start.
    int         eng_delay  = 1;
    int         eng_cnt    = 0;
    logic       eng_invert = 1'b0;
    logic [7:0] eng_val    = 8'h00;
    logic [7:0] eng_res    = 8'h00;

    initial begin
        bus.filt_done   = 1'b0;
        bus.filt_result = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus.filt_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    bus.filt_done   = 1'b1;
                    bus.filt_result = eng_res;
                end
            end
            if (bus.filt_start) begin
                eng_cnt = eng_delay;
                eng_res = eng_invert ? ~bus.filt_in : eng_val;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({bus.req_ready, bus.filt_start, bus.filt_ch, bus.filt_in, bus.out_valid,
                    bus.out_ch, bus.out_data, bus.busy, bus.timeout_err});
    endfunction

    task automatic do_reset();
        next_cycle();
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        settle();
        chk("reset_outputs", all_outputs(), 32'h0);
    endtask

    function automatic int rr_pick(input logic [3:0] p, input int ptr);
        for (int k = 0; k < NUM_CH; k++) begin
            if (p[(ptr + k) % NUM_CH]) return (ptr + k) % NUM_CH;
        end
        return -1;
    endfunction

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] word;
        int          delay;
        logic [7:0]  res;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_ch;
        logic [7:0]  exp_in;
        logic [7:0]  exp_out;
        int          exp_lat;
        logic        exp_terr;
    } vec_t;

    vec_t vecs[8];

    // randomized-run model state
    int         m_rr, m_acc, m_ch, m_d;
    logic       m_busy, m_terr, m_to;
    logic [7:0] m_in, m_res;
    logic [3:0] pend;
    logic [7:0] pdata[4];

    initial begin
        int n, lat, ng;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;

        // rr pointer evolves across entries: 0,3,0,2,1,1,0,3
        vecs[0] = '{4'b0100, 32'h445A2211, 2,   8'h33, 4'b0100, 2'd2, 8'h5A, 8'h33, 4,  1'b0};
        vecs[1] = '{4'b1111, 32'hD3C2B1A0, 1,   8'h81, 4'b1000, 2'd3, 8'hD3, 8'h81, 3,  1'b0};
        vecs[2] = '{4'b1010, 32'hD3C2B1A0, 3,   8'h9C, 4'b0010, 2'd1, 8'hB1, 8'h9C, 5,  1'b0};
        vecs[3] = '{4'b0011, 32'hD3C2B1A0, 1,   8'hF0, 4'b0001, 2'd0, 8'hA0, 8'hF0, 3,  1'b0};
        vecs[4] = '{4'b0001, 32'h04030201, 5,   8'h5C, 4'b0001, 2'd0, 8'h01, 8'h5C, 7,  1'b0};
        vecs[5] = '{4'b1001, 32'h04030201, 64,  8'h7E, 4'b1000, 2'd3, 8'h04, 8'h7E, 66, 1'b0};
        vecs[6] = '{4'b0100, 32'h04030201, 200, 8'hBB, 4'b0100, 2'd2, 8'h03, 8'h00, 66, 1'b1};
        vecs[7] = '{4'b1100, 32'h04030201, 1,   8'h66, 4'b1000, 2'd3, 8'h04, 8'h66, 3,  1'b1};

        do_reset();

        for (int i = 0; i < 8; i++) begin
            next_cycle();
            bus.req_valid = vecs[i].mask;
            bus.req_data  = vecs[i].word;
            eng_delay     = vecs[i].delay;
            eng_val       = vecs[i].res;
            eng_invert    = 1'b0;
            bus.out_ready = 1'b1;
            settle();
            n = 0;
            while (bus.req_ready == '0 && n < 8) begin
                next_cycle();
                settle();
                n++;
            end
            chk("vec_ready", 32'(bus.req_ready), 32'(vecs[i].exp_ready));
            next_cycle();
            bus.req_valid = '0;
            settle();
            chk("vec_start", 32'(bus.filt_start), 32'h1);
            chk("vec_tag", 32'({bus.filt_ch, bus.filt_in}), 32'({vecs[i].exp_ch, vecs[i].exp_in}));
            lat = 1;
            while (!bus.out_valid && lat < 100) begin
                next_cycle();
                settle();
                lat++;
            end
            chk("vec_latency", lat, vecs[i].exp_lat);
            chk("vec_result", 32'({bus.out_ch, bus.out_data}), 32'({vecs[i].exp_ch, vecs[i].exp_out}));
            chk("vec_terr", 32'(bus.timeout_err), 32'(vecs[i].exp_terr));
            next_cycle();
            settle();
            chk("vec_idle", 32'({bus.out_valid, bus.busy}), 32'h0);
        end

        // all channels held valid: grants 0,1,2,3,0,1 every 4 cycles
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h13121110;
        eng_delay     = 1;
        eng_val       = 8'h11;
        bus.out_ready = 1'b1;
        settle();
        ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            if (c > 0) begin
                next_cycle();
                settle();
            end
            if (bus.req_ready != '0) begin
                chk("rr_order", 32'(bus.req_ready), 32'(4'b0001 << (ng % 4)));
                chk("rr_spacing", c, 4 * ng);
                ng++;
            end
        end
        chk("rr_count", ng, 6);

        // downstream stall for 10 cycles with other channels pending
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h00003C00;
        eng_delay     = 1;
        eng_val       = 8'hA7;
        bus.out_ready = 1'b0;
        settle();
        chk("stall_accept", 32'(bus.req_ready), 32'h2);
        next_cycle();
        bus.req_valid = 4'b1101;
        settle();
        n = 0;
        while (!bus.out_valid && n < 10) begin
            next_cycle();
            settle();
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                next_cycle();
                settle();
            end
            chk("stall_hold", 32'({bus.out_valid, bus.out_ch, bus.out_data, bus.req_ready}),
                32'({1'b1, 2'd1, 8'hA7, 4'b0000}));
        end
        next_cycle();
        bus.out_ready = 1'b1;
        settle();
        chk("stall_release", 32'({bus.out_valid, bus.out_ch, bus.out_data, bus.req_ready}),
            32'({1'b1, 2'd1, 8'hA7, 4'b0000}));
        next_cycle();
        bus.out_ready = 1'b0;
        settle();
        chk("stall_next_grant", 32'({bus.out_valid, bus.req_ready}), 32'({1'b0, 4'b0100}));

        // reset during WAIT; the late engine done must be ignored
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h00009900;
        eng_delay     = 20;
        eng_val       = 8'hEE;
        bus.out_ready = 1'b1;
        settle();
        chk("mid_accept", 32'(bus.req_ready), 32'h2);
        next_cycle();
        bus.req_valid = '0;
        settle();
        next_cycle();
        settle();
        next_cycle();
        settle();
        chk("mid_in_wait", 32'({bus.busy, bus.filt_start, bus.out_valid}), 32'({1'b1, 1'b0, 1'b0}));
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            next_cycle();
            settle();
            chk("post_reset_quiet", all_outputs(), 32'h0);
        end
        next_cycle();
        bus.req_valid = 4'b1001;
        settle();
        chk("post_reset_rr", 32'(bus.req_ready), 32'h1);

        // randomized run against a transaction-level model
        do_reset();
        m_rr       = 0;
        m_busy     = 1'b0;
        m_terr     = 1'b0;
        m_to       = 1'b0;
        m_acc      = 0;
        m_ch       = 0;
        m_d        = 0;
        m_in       = 8'h00;
        m_res      = 8'h00;
        pend       = '0;
        eng_invert = 1'b1;
        for (int k = 0; k < NUM_CH; k++) pdata[k] = 8'h00;
        for (int c = 0; c < 1500; c++) begin
            int g, d, r;
            logic [3:0] exp_ready;
            logic exp_start, exp_oval, exp_terr;
            next_cycle();
            for (int k = 0; k < NUM_CH; k++) begin
                if (!pend[k] && $urandom_range(0, 3) == 0) begin
                    pend[k]  = 1'b1;
                    pdata[k] = 8'($urandom);
                end
                bus.req_data[8*k +: 8] = pend[k] ? pdata[k] : 8'($urandom);
            end
            bus.req_valid = pend;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            settle();

            exp_ready = '0;
            g = -1;
            if (!m_busy && pend != '0) begin
                g = rr_pick(pend, m_rr);
                exp_ready[g] = 1'b1;
            end
            exp_start = m_busy && (c == m_acc + 1);
            exp_oval  = m_busy && (c >= m_acc + 2 + m_d);
            exp_terr  = m_terr || (exp_oval && m_to);

            chk("rnd_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("rnd_start", 32'(bus.filt_start), 32'(exp_start));
            chk("rnd_out_valid", 32'(bus.out_valid), 32'(exp_oval));
            chk("rnd_busy", 32'(bus.busy), 32'(m_busy));
            chk("rnd_timeout_err", 32'(bus.timeout_err), 32'(exp_terr));
            if (exp_start) begin
                chk("rnd_tag", 32'({bus.filt_ch, bus.filt_in}), 32'({2'(m_ch), m_in}));
            end
            if (exp_oval) begin
                chk("rnd_result", 32'({bus.out_ch, bus.out_data}), 32'({2'(m_ch), m_res}));
            end

            if (exp_oval && bus.out_ready) begin
                m_busy = 1'b0;
                m_rr   = (m_ch + 1) % NUM_CH;
                if (m_to) m_terr = 1'b1;
            end else if (g >= 0) begin
                r = $urandom_range(0, 99);
                if (r < 85)      d = $urandom_range(1, 6);
                else if (r < 90) d = TIMEOUT - 1;
                else if (r < 95) d = TIMEOUT;
                else             d = 150;
                eng_delay = d;
                m_busy    = 1'b1;
                m_acc     = c;
                m_ch      = g;
                m_in      = pdata[g];
                m_to      = (d > TIMEOUT);
                m_d       = m_to ? TIMEOUT : d;
                m_res     = m_to ? 8'h00 : ~pdata[g];
                pend[g]   = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/avg_filter_scheduler.md
Name: avg_filter_scheduler

Overview:
Time-multiplexes one shared moving-average filter engine across NUM_CH sensor channels. Each channel requests with a valid/ready handshake; requests are served round-robin. For each accepted sample the block issues one start pulse, tagged with the channel number, to the filter engine. It waits for the engine's done, with a timeout, then presents the tagged result downstream with valid/ready backpressure. Only one transaction is in flight at a time.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
CH_W, 2, width of channel index; must satisfy 2**CH_W >= NUM_CH
TIMEOUT, 64, max cycles spent in WAIT before the transaction is aborted (>=2)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_CH  per-channel sample valid
req_data  in  8*NUM_CH  per-channel 8-bit sample; channel k occupies bits [8k+7:8k]
req_ready  out  NUM_CH  one-hot accept strobe, high for exactly one cycle per accepted sample
filt_start  out  1  one-cycle start pulse to filter engine
filt_ch  out  CH_W  channel tag for filter engine; held from ISSUE until return to IDLE
filt_in  out  8  sample to filter engine; held like filt_ch
filt_done  in  1  engine result strobe; only sampled in WAIT
filt_result  in  8  engine result; valid while filt_done=1
out_valid  out  1  result valid
out_ch  out  CH_W  channel of result
out_data  out  8  filtered result
out_ready  in  1  downstream accept
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky; set on any timeout; cleared only by reset

Behaviour:
- Reset (synchronous, reset=1 at a rising edge): state=IDLE, rr_ptr=0, timer=0. All outputs = 0: req_ready, filt_start, filt_ch, filt_in, out_valid, out_ch, out_data, busy, timeout_err. Reset has priority over every other event.
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE, with any req_valid high:
  - grant = first channel with req_valid=1, searching rr_ptr, rr_ptr+1, ... mod NUM_CH.
  - req_ready[grant]=1 combinationally in this cycle.
  - On the edge, latch req_data[grant] into filt_in and grant into filt_ch, then go to ISSUE.
- IDLE, with no req_valid: stay in IDLE; req_ready all 0.
- ISSUE: filt_start=1 for this single cycle; timer cleared to 0; next state WAIT.
- WAIT:
  - If filt_done=1: latch filt_result into out_data and filt_ch into out_ch; go to OUT.
  - Otherwise timer increments. When timer reaches TIMEOUT-1 without done: out_data=8'h00, out_ch=filt_ch, timeout_err set to 1, go to OUT.
  - filt_done arriving in the same cycle as the timeout condition: done wins and timeout_err is not set.
- OUT: out_valid=1. out_data and out_ch are stable until out_ready=1. On the handshake, rr_ptr = (filt_ch+1) mod NUM_CH, out_valid drops on the next cycle, and the next state is IDLE.
- Next-request turnaround: IDLE is always re-entered for at least one cycle before the next grant. Maximum throughput is one sample per 4 cycles with zero engine latency.
- filt_done outside WAIT is ignored.
- req_valid is a level. A channel whose valid is held high is granted again only after every other requesting channel has been served once.
- Latency:
  - Accept in cycle T, filt_start in T+1, earliest done sampled in T+2, out_valid in T+3.
  - If done arrives D cycles after filt_start (D>=1), out_valid asserts at T+2+D.
- Reset mid-operation (ISSUE/WAIT/OUT): the transaction is abandoned and its result is never output. rr_ptr returns to 0. An engine done arriving after reset is ignored.
- Downstream stall: OUT may hold indefinitely. No new request is accepted, and all req_ready stay 0 during that time.

Test Plan:
- Only ch2 valid with data 0x5A; engine returns done with 0x33 two cycles after start -> req_ready=4'b0100 for exactly 1 cycle, filt_start 1 cycle later with filt_ch=2 and filt_in=0x5A; out_valid=1, out_ch=2, out_data=0x33 once done is sampled.
- All 4 channels held valid, engine done 1 cycle after each start, out_ready=1 -> grants in order 0,1,2,3,0,1; one result every 4 cycles.
- out_ready held low 10 cycles in OUT -> out_valid, out_ch and out_data stable for all 10 cycles; req_ready stays 0 despite pending requests; on the 11th cycle out_ready=1 completes the handshake.
- filt_done never asserted, TIMEOUT=64 -> out_valid with out_data=0x00 after 64 cycles in WAIT; timeout_err=1 and remains 1 after further successful transactions.
- filt_done asserted exactly in the timeout cycle with result 0x7E -> out_data=0x7E, timeout_err stays 0.
- Reset asserted during WAIT, then engine done pulses -> no out_valid and all outputs 0. A subsequent request from ch3 with ch0 also valid grants ch0 first, because rr_ptr=0.
